// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI read and write paths: FSM state encoding,
// CRC polynomial, command layout and common timing defaults.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_DONE
  } adc_spi_state_e;

  localparam logic [7:0] ADC_CRC_POLY = 8'h07;
  localparam int ADC_CRC_BITS = 8;

  localparam int ADC_CMD_BITS   = 16;
  localparam int ADC_RDATA_BITS = 24;
  // MSB of the command word selects the access direction; 1 means read.
  localparam int ADC_RW_BIT     = ADC_CMD_BITS - 1;

  localparam int ADC_HALF_PER  = 3;
  localparam int ADC_SETUP_CYC = 4;
  localparam int ADC_HOLD_CYC  = 2;

  function automatic logic [ADC_CMD_BITS-1:0] adc_read_cmd(input logic [ADC_RW_BIT-1:0] addr);
    return {1'b1, addr};
  endfunction

endpackage

// File: rtl/adc_crc8_serial.sv
// Bit-serial CRC-8 (MSB first) with synchronous clear and enable; one data bit
// per enabled clock. Shared by the ADC read and write paths.
module adc_crc8_serial
  import adc_spi_pkg::*;
#(
  parameter logic [7:0] POLY = ADC_CRC_POLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       d_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ d_i;
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/spi_adc_reader.sv
// SPI mode-0 read master for the radar ADC: shifts out a command, captures the
// response word. Define ADC_RD_CRC_EN to append and check a trailing CRC-8 byte.
//
//   state | meaning
//   IDLE  | CS high, waiting for start
//   SETUP | CS low, command MSB on MOSI, SCLK low
//   HIGH  | SCLK high half-period, MISO sampled on first cycle
//   LOW   | SCLK low half-period, MOSI advances on entry
//   HOLD  | SCLK low, CS still asserted after the last bit
//   DONE  | CS high, rdata/rdata_valid presented
module spi_adc_reader
  import adc_spi_pkg::*;
#(
  parameter int CMD_BITS   = ADC_CMD_BITS,
  parameter int RDATA_BITS = ADC_RDATA_BITS,
  parameter int HALF_PER   = ADC_HALF_PER,
  parameter int SETUP_CYC  = ADC_SETUP_CYC,
  parameter int HOLD_CYC   = ADC_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CMD_BITS-1:0]   cmd,
  output logic                  busy,
  output logic [RDATA_BITS-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  crc_err,
  output logic                  o_cs,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso
);

`ifdef ADC_RD_CRC_EN
  localparam int CRC_BITS = ADC_CRC_BITS;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int TOTAL = CMD_BITS + RDATA_BITS + CRC_BITS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PMAX  = (HALF_PER > SETUP_CYC) ?
                         ((HALF_PER > HOLD_CYC) ? HALF_PER : HOLD_CYC) :
                         ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam int PW    = $clog2(PMAX + 1);

  localparam logic [PW-1:0] HALF_LD  = PW'(HALF_PER - 1);
  localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [CW-1:0] CMD_C    = CW'(CMD_BITS);
  localparam logic [CW-1:0] DEND_C   = CW'(CMD_BITS + RDATA_BITS);

  adc_spi_state_e        state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [CMD_BITS-1:0]   sh_q, sh_d;
  logic [RDATA_BITS-1:0] cap_q, rdata_q;
  logic                  miso_q, valid_q, cs_q, sclk_q;
  logic                  cs_d, sclk_d, done_d;
  logic                  accept, cap_en, data_bit;

  assign accept   = (state_q == ST_IDLE) && start;
  assign cap_en   = (state_q == ST_HIGH) && (ph_q == HALF_LD) && (bit_q >= CMD_C);
  assign data_bit = (bit_q < DEND_C);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          ph_d    = SETUP_LD;
          bit_d   = '0;
          sh_d    = cmd;
        end
      end
      ST_SETUP: begin
        if (ph_q == '0) begin
          state_d = ST_HIGH;
          ph_d    = HALF_LD;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (ph_q == '0) begin
          state_d = ST_LOW;
          ph_d    = HALF_LD;
          bit_d   = bit_q + 1'b1;
          // zero fill leaves MOSI low once the command has been shifted out
          sh_d    = {sh_q[CMD_BITS-2:0], 1'b0};
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (ph_q == '0) begin
          if (bit_q == TOTAL_C) begin
            state_d = ST_HOLD;
            ph_d    = HOLD_LD;
          end else begin
            state_d = ST_HIGH;
            ph_d    = HALF_LD;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (ph_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cs_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
    sclk_d = (state_d == ST_HIGH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
      cap_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      miso_q  <= i_miso;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      valid_q <= done_d;
      if (cap_en && data_bit) begin
        cap_q <= {cap_q[RDATA_BITS-2:0], miso_q};
      end
      if (done_d) begin
        rdata_q <= cap_q;
      end
    end
  end

`ifdef ADC_RD_CRC_EN
  logic [7:0] crc_calc, crc_rx_q;
  logic       crc_err_q;

  adc_crc8_serial #(.POLY(ADC_CRC_POLY)) u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (cap_en && data_bit),
    .d_i   (miso_q),
    .crc_o (crc_calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_rx_q  <= 8'h00;
      crc_err_q <= 1'b0;
    end else begin
      if (cap_en && !data_bit) begin
        crc_rx_q <= {crc_rx_q[6:0], miso_q};
      end
      if (done_d) begin
        crc_err_q <= (crc_calc != crc_rx_q);
      end
    end
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  // The bit counter is sized to hold TOTAL; exceeding it means the frame control is broken.
  assert property (@(posedge clk) disable iff (rst) bit_q <= TOTAL_C);

  assign busy        = (state_q != ST_IDLE);
  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign o_cs        = cs_q;
  assign o_sclk      = sclk_q;
  assign o_mosi      = sh_q[CMD_BITS-1];

endmodule

// File: tb/tb_spi_adc_reader.sv
// Self-checking bench for spi_adc_reader: bus-level ADC model plus directed and
// randomized read frames; CRC scenarios follow ADC_RD_CRC_EN.
`timescale 1ns/1ps
module tb_spi_adc_reader;
  import adc_spi_pkg::*;

  localparam int CMD_BITS   = 16;
  localparam int RDATA_BITS = 24;
  localparam int HALF_PER   = 3;
  localparam int SETUP_CYC  = 4;
  localparam int HOLD_CYC   = 2;
`ifdef ADC_RD_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int TOTAL     = CMD_BITS + RDATA_BITS + CRC_BITS;
  localparam int RESP_BITS = RDATA_BITS + CRC_BITS;
  localparam int LATENCY   = 1 + SETUP_CYC + 2 * HALF_PER * TOTAL + HOLD_CYC;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [CMD_BITS-1:0]   cmd = '0;
  logic                  busy, rdata_valid, crc_err, o_cs, o_sclk, o_mosi;
  logic [RDATA_BITS-1:0] rdata;
  logic                  i_miso = 1'b0;

  always #5 clk = ~clk;

  spi_adc_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmd         (cmd),
    .busy        (busy),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .crc_err     (crc_err),
    .o_cs        (o_cs),
    .o_sclk      (o_sclk),
    .o_mosi      (o_mosi),
    .i_miso      (i_miso)
  );

  int checks   = 0;
  int failures = 0;

  // ADC-side model: records bus timing and serves the queued response words.
  int cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int n_rise = 0, cs_fall_cyc = 0, first_rise_cyc = 0, last_fall_cyc = 0, cs_rise_cyc = 0;
  int mosi_unstable = 0, mosi_tail_ones = 0, cs_high_run = 0, last_gap = 0;
  logic [CMD_BITS-1:0]  mosi_cmd = '0;
  logic [RESP_BITS-1:0] resp_q[$];
  logic [RESP_BITS-1:0] cur_resp = '0;

  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !o_cs) begin
      cs_fall_cyc    = cyc;
      last_gap       = cs_high_run;
      n_rise         = 0;
      mosi_unstable  = 0;
      mosi_tail_ones = 0;
      mosi_cmd       = '0;
      first_rise_cyc = -1;
      cur_resp       = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
      i_miso         = 1'b0;
    end
    if (o_cs) cs_high_run++; else cs_high_run = 0;
    if (!prev_cs && o_cs) cs_rise_cyc = cyc;
    if (!prev_sclk && o_sclk) begin
      if (n_rise == 0) first_rise_cyc = cyc;
      if (o_mosi !== prev_mosi) mosi_unstable++;
      if (n_rise < CMD_BITS) mosi_cmd = {mosi_cmd[CMD_BITS-2:0], o_mosi};
      else if (o_mosi) mosi_tail_ones++;
      n_rise++;
    end
    if (prev_sclk && !o_sclk) begin
      last_fall_cyc = cyc;
      if (n_rise >= CMD_BITS && n_rise < TOTAL) i_miso = cur_resp[RESP_BITS-1-(n_rise-CMD_BITS)];
      else i_miso = 1'b0;
    end
    prev_cs   = o_cs;
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
  end

  function automatic logic [7:0] crc8_ref(input logic [RDATA_BITS-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int b = RDATA_BITS / 8 - 1; b >= 0; b--) begin
      c = c ^ d[b*8 +: 8];
      for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [RESP_BITS-1:0] make_resp(input logic [RDATA_BITS-1:0] d,
                                                     input logic [7:0] flip);
`ifdef ADC_RD_CRC_EN
    return {d, crc8_ref(d) ^ flip};
`else
    return (flip == 8'h00) ? d : d;
`endif
  endfunction

  // Issues one read and waits (bounded) for the valid strobe; returns measurements only.
  task automatic do_read(input logic [CMD_BITS-1:0] c, input logic [RESP_BITS-1:0] resp,
                         output int lat, output logic [RDATA_BITS-1:0] got,
                         output logic got_crc, output bit timed_out);
    resp_q.push_back(resp);
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    lat = 0; got = '0; got_crc = 1'b0; timed_out = 1'b1;
    for (int k = 1; k <= LATENCY + 50; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (rdata_valid) begin
        lat = k; got = rdata; got_crc = crc_err; timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", o_cs); end
    checks++; if (o_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", o_sclk); end
    checks++; if (o_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", o_mosi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rdata_valid); end
    checks++; if (crc_err !== 1'b0) begin failures++; $display("FAIL reset_crc got=%b exp=0", crc_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || o_cs !== 1'b1) begin failures++; $display("FAIL post_reset_idle busy=%b cs=%b exp busy=0 cs=1", busy, o_cs); end
  endtask

  task automatic test_basic();
    int lat; logic [RDATA_BITS-1:0] got; logic gc; bit to;
    do_read(16'h8012, make_resp(24'hA5C33C, 8'h00), lat, got, gc, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=valid"); end
    checks++; if (lat != LATENCY) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LATENCY); end
    checks++; if (got !== 24'hA5C33C) begin failures++; $display("FAIL basic_rdata got=%h exp=a5c33c", got); end
    checks++; if (gc !== 1'b0) begin failures++; $display("FAIL basic_crc got=%b exp=0", gc); end
    @(negedge clk); #1;
    checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_width got=%b exp=0", rdata_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    checks++; if (rdata !== 24'hA5C33C) begin failures++; $display("FAIL basic_rdata_hold got=%h exp=a5c33c", rdata); end
    checks++; if (mosi_cmd !== 16'h8012) begin failures++; $display("FAIL basic_mosi_cmd got=%h exp=8012", mosi_cmd); end
    checks++; if (mosi_tail_ones != 0) begin failures++; $display("FAIL basic_mosi_tail got=%0d exp=0", mosi_tail_ones); end
    checks++; if (mosi_unstable != 0) begin failures++; $display("FAIL mosi_stable got=%0d exp=0", mosi_unstable); end
    checks++; if (n_rise != TOTAL) begin failures++; $display("FAIL sclk_count got=%0d exp=%0d", n_rise, TOTAL); end
    checks++; if (first_rise_cyc - cs_fall_cyc != SETUP_CYC) begin failures++; $display("FAIL setup_time got=%0d exp=%0d", first_rise_cyc - cs_fall_cyc, SETUP_CYC); end
    checks++; if (cs_rise_cyc - last_fall_cyc < HOLD_CYC) begin failures++; $display("FAIL hold_time got=%0d exp>=%0d", cs_rise_cyc - last_fall_cyc, HOLD_CYC); end
    checks++; if (cs_rise_cyc - cs_fall_cyc != LATENCY - 1) begin failures++; $display("FAIL cs_low_len got=%0d exp=%0d", cs_rise_cyc - cs_fall_cyc, LATENCY - 1); end
  endtask

  task automatic test_random();
    int lat; logic [RDATA_BITS-1:0] got, d; logic gc; bit to; logic [CMD_BITS-1:0] c;
    for (int i = 0; i < 4; i++) begin
      c = adc_read_cmd(15'($urandom));
      d = 24'($urandom);
      do_read(c, make_resp(d, 8'h00), lat, got, gc, to);
      @(negedge clk); #1;
      checks++; if (to || got !== d) begin failures++; $display("FAIL rand_rdata[%0d] got=%h exp=%h timeout=%0d", i, got, d, to); end
      checks++; if (lat != LATENCY) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, LATENCY); end
      checks++; if (mosi_cmd !== c) begin failures++; $display("FAIL rand_mosi[%0d] got=%h exp=%h", i, mosi_cmd, c); end
      checks++; if (gc !== 1'b0) begin failures++; $display("FAIL rand_crc[%0d] got=%b exp=0", i, gc); end
    end
  endtask

  task automatic test_ignored_start();
    int lat, busy_drops, extra_valid, cs_low; logic [RDATA_BITS-1:0] got;
    lat = 0; busy_drops = 0; extra_valid = 0; cs_low = 0; got = '0;
    resp_q.push_back(make_resp(24'h3C5A96, 8'h00));
    @(negedge clk);
    start = 1'b1; cmd = 16'h8ABC;
    for (int k = 1; k <= LATENCY + 50; k++) begin
      @(negedge clk);
      start = (k == 10 || k == 50);
      if (k == 10 || k == 50) cmd = 16'h7FFF;
      if (rdata_valid) begin lat = k; got = rdata; break; end
      if (!busy) busy_drops++;
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdata_valid) extra_valid++;
      if (!o_cs) cs_low++;
    end
    #1;
    checks++; if (lat != LATENCY) begin failures++; $display("FAIL ign_latency got=%0d exp=%0d", lat, LATENCY); end
    checks++; if (got !== 24'h3C5A96) begin failures++; $display("FAIL ign_rdata got=%h exp=3c5a96", got); end
    checks++; if (busy_drops != 0) begin failures++; $display("FAIL ign_busy_cont got=%0d exp=0", busy_drops); end
    checks++; if (extra_valid != 0 || cs_low != 0) begin failures++; $display("FAIL ign_no_queue got valid=%0d cs_low=%0d exp=0", extra_valid, cs_low); end
    checks++; if (mosi_cmd !== 16'h8ABC) begin failures++; $display("FAIL ign_mosi got=%h exp=8abc", mosi_cmd); end
  endtask

  task automatic test_reset_mid();
    int rises, valids, lat; logic ps; logic [RDATA_BITS-1:0] got; logic gc; bit to; bit hit;
    rises = 0; valids = 0; ps = 1'b0; hit = 1'b0;
    resp_q.push_back(make_resp(24'hFFFFFF, 8'h00));
    @(negedge clk);
    start = 1'b1; cmd = 16'h8055;
    for (int k = 1; k <= LATENCY; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (o_sclk && !ps) rises++;
      ps = o_sclk;
      if (rises == 21) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach got=%0d rises exp=21", rises); end
    rst = 1'b1;
    #1;
    checks++; if (o_cs !== 1'b1 || o_sclk !== 1'b0) begin failures++; $display("FAIL rstmid_async got cs=%b sclk=%b exp cs=1 sclk=0", o_cs, o_sclk); end
    checks++; if (busy !== 1'b0 || rdata !== '0) begin failures++; $display("FAIL rstmid_state got busy=%b rdata=%h exp 0/0", busy, rdata); end
    repeat (3) begin @(negedge clk); if (rdata_valid) valids++; end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (rdata_valid) valids++; end
    checks++; if (valids != 0 || rdata !== '0) begin failures++; $display("FAIL rstmid_no_valid got valids=%0d rdata=%h exp 0/0", valids, rdata); end
    do_read(adc_read_cmd(15'h0042), make_resp(24'h000001, 8'h00), lat, got, gc, to);
    checks++; if (to || got !== 24'h000001 || lat != LATENCY) begin failures++; $display("FAIL rstmid_reread got=%h lat=%0d exp=000001 lat=%0d", got, lat, LATENCY); end
  endtask

  task automatic test_back_to_back();
    int nv; bit saw_idle; logic [RDATA_BITS-1:0] d0, d1; int late_busy;
    nv = 0; saw_idle = 1'b0; d0 = '0; d1 = '1; late_busy = 0;
    resp_q.push_back(make_resp(24'hFFFFFF, 8'h00));
    resp_q.push_back(make_resp(24'h000000, 8'h00));
    @(negedge clk);
    start = 1'b1; cmd = 16'h8100;
    for (int k = 1; k <= 2 * LATENCY + 50; k++) begin
      @(negedge clk);
      if (rdata_valid) begin
        if (nv == 0) d0 = rdata; else d1 = rdata;
        nv++;
        if (nv == 2) break;
      end
      if (nv == 1 && !busy) saw_idle = 1'b1;
      if (saw_idle && busy) start = 1'b0;
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (busy) late_busy++; end
    #1;
    checks++; if (nv != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", nv); end
    checks++; if (d0 !== 24'hFFFFFF || d1 !== 24'h000000) begin failures++; $display("FAIL b2b_data got=%h,%h exp=ffffff,000000", d0, d1); end
    checks++; if (!saw_idle || last_gap < 2) begin failures++; $display("FAIL b2b_cs_gap got=%0d idle=%0d exp>=2", last_gap, saw_idle); end
    checks++; if (late_busy != 0) begin failures++; $display("FAIL b2b_no_third got=%0d exp=0", late_busy); end
  endtask

  task automatic test_crc();
    int lat; logic [RDATA_BITS-1:0] got; logic gc; bit to;
`ifdef ADC_RD_CRC_EN
    do_read(16'h8020, make_resp(24'h123456, 8'h00), lat, got, gc, to);
    checks++; if (to || gc !== 1'b0 || got !== 24'h123456) begin failures++; $display("FAIL crc_good got err=%b rdata=%h exp 0/123456", gc, got); end
    do_read(16'h8020, make_resp(24'h123456, 8'h01), lat, got, gc, to);
    checks++; if (to || gc !== 1'b1 || got !== 24'h123456) begin failures++; $display("FAIL crc_flip0 got err=%b rdata=%h exp 1/123456", gc, got); end
    do_read(16'h8020, make_resp(24'h123456, 8'h80), lat, got, gc, to);
    checks++; if (to || gc !== 1'b1 || lat != LATENCY) begin failures++; $display("FAIL crc_flip7 got err=%b lat=%0d exp 1/%0d", gc, lat, LATENCY); end
`else
    do_read(16'h8020, make_resp(24'h123456, 8'h00), lat, got, gc, to);
    checks++; if (to || gc !== 1'b0 || got !== 24'h123456) begin failures++; $display("FAIL crc_tied got err=%b rdata=%h exp 0/123456", gc, got); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_crc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
